multictx_cswitch_ctrl: RTL

MULTICTX_CSWITCH_CTRL -- requirements
Module: multictx_cswitch_ctrl

---
 rtl/multictx_cswitch_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/multictx_cswitch_ctrl.sv
// multictx_cswitch_ctrl
//   Context-switch controller for a systolic array. Counts input pops per
//   context, raises a context-done pulse at the end of each context, queues
//   context-switch requests (automatic on context done, or forced manually),
//   and runs a propagation sequence that walks a one-hot cswitch strobe
//   across the array columns before signalling that propagation has finished.
//
// Ports
//   i_clk            clock
//   i_rstn           asynchronous active-low reset
//   i_incntlim       pops per context minus one
//   i_clear          synchronous clear, overrides every other event
//   i_pipeline_en    global pipeline advance enable
//   i_wei_pop_en     weight stream pop enable
//   i_act_pop_en     activation stream pop enable
//   i_cswitch_en     propagation advance enable
//   i_cswitch_force  manual switch request (sampled every cycle)
//   i_mode           0 = request on context done, 1 = manual only
//   o_cdone          one-cycle pulse after the last pop of a context
//   o_cswitch_done   combinational pulse on the final advancing propagation cycle
//   o_cswitch_arr    per-column cswitch strobe, at most one bit high per cycle
//   o_pend_cnt       number of queued switch requests
//   o_ctx_cnt        completed propagations, wraps modulo 2^CTX_W
//   o_overflow       sticky: a request arrived while the queue was full
//
// FSM states
//   state  | meaning
//   IDLE   | no propagation running, waiting for a queued request and adv
//   PROP   | propagation running, cscnt counts advancing cycles 0..PROP_LEN-1

module multictx_cswitch_ctrl #(
  parameter int X           = 3,
  parameter int Y           = 3,
  parameter int IDX_W       = 11,
  parameter int PE_LAT      = 5,
  parameter int EXTRA_CSREG = 0,
  parameter int PEND_W      = 2,
  parameter int CTX_W       = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [IDX_W-1:0] i_incntlim,
  input  logic             i_clear,
  input  logic             i_pipeline_en,
  input  logic             i_wei_pop_en,
  input  logic             i_act_pop_en,
  input  logic             i_cswitch_en,
  input  logic             i_cswitch_force,
  input  logic             i_mode,
  output logic             o_cdone,
  output logic             o_cswitch_done,
  output logic [0:X-1]     o_cswitch_arr,
  output logic [PEND_W-1:0] o_pend_cnt,
  output logic [CTX_W-1:0] o_ctx_cnt,
  output logic             o_overflow
);

  localparam int PROP_LEN = PE_LAT + X + Y - 1;
  localparam int CS_W     = (PROP_LEN > 1) ? $clog2(PROP_LEN) : 1;
  // Downstream register stages are compensated by firing column strobes earlier.
  localparam int ARR_BASE = PE_LAT - EXTRA_CSREG;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PROP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CS_W-1:0]   cscnt_q, cscnt_d;
  logic [IDX_W-1:0]  incnt_q;
  logic              cdone_q;
  logic [PEND_W-1:0] pend_q;
  logic              ovf_q;
  logic [CTX_W-1:0]  ctx_q;
  logic [0:X-1]      arr_q, arr_d;

  logic pop, adv, at_lim, cdone_evt, req, have_work, cs_last;
  logic start, done;

  assign pop       = i_pipeline_en & i_wei_pop_en & i_act_pop_en;
  assign adv       = i_pipeline_en & i_cswitch_en;
  assign at_lim    = (incnt_q == i_incntlim);
  assign cdone_evt = pop & at_lim;
  // Force and auto request in the same cycle collapse into a single request.
  assign req       = (cdone_evt & ~i_mode) | i_cswitch_force;
  assign have_work = (pend_q != '0) | req;
  assign cs_last   = (cscnt_q == CS_W'(PROP_LEN - 1));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      cscnt_q <= '0;
    end else begin
      state_q <= state_d;
      cscnt_q <= cscnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cscnt_d = cscnt_q;
    start   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (adv && have_work) begin
          state_d = S_PROP;
          cscnt_d = '0;
          start   = 1'b1;
        end
      end
      S_PROP: begin
        if (adv) begin
          if (cs_last) begin
            done    = 1'b1;
            cscnt_d = '0;
            // Chain straight into the next propagation when work is queued.
            if (have_work) begin
              start = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cscnt_d = cscnt_q + CS_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cscnt_d = '0;
      end
    endcase
    // Clear aborts everything, including a propagation about to finish.
    if (i_clear) begin
      state_d = S_IDLE;
      cscnt_d = '0;
      start   = 1'b0;
      done    = 1'b0;
    end
  end

  always_comb begin
    arr_d = '0;
    for (int i = 0; i < X; i++) begin
      arr_d[i] = (state_q == S_PROP) && adv && (cscnt_q == CS_W'(ARR_BASE + i));
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      incnt_q <= '0;
      cdone_q <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      ctx_q   <= '0;
      arr_q   <= '0;
    end else if (i_clear) begin
      incnt_q <= '0;
      cdone_q <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      ctx_q   <= '0;
      arr_q   <= '0;
    end else begin
      if (pop) begin
        incnt_q <= at_lim ? '0 : incnt_q + IDX_W'(1);
      end
      cdone_q <= cdone_evt;
      // start always implies have_work, so decrementing from zero cannot occur
      // without a matching incoming request.
      case ({req, start})
        2'b10: begin
          if (pend_q == PEND_MAX) begin
            ovf_q <= 1'b1;
          end else begin
            pend_q <= pend_q + PEND_W'(1);
          end
        end
        2'b01:   pend_q <= pend_q - PEND_W'(1);
        default: pend_q <= pend_q;
      endcase
      if (done) begin
        ctx_q <= ctx_q + CTX_W'(1);
      end
      arr_q <= arr_d;
    end
  end

  assign o_cdone        = cdone_q;
  assign o_cswitch_done = done;
  assign o_cswitch_arr  = arr_q;
  assign o_pend_cnt     = pend_q;
  assign o_ctx_cnt      = ctx_q;
  assign o_overflow     = ovf_q;

endmodule
